hazard_ctrl: RTL and testbench

Parametrised hazard detection and forwarding controller for the 5-stage pipeline. It replaces the ad-hoc stall/forward logic in the top level. It drives forwarding selects for both decode source operands and a load-use stall with configurable extra memory latency. A registered FSM holds the stall for multi-cycle loads, absorbs an external memory-busy stall, and clears on a pipeline redirect.

---
 rtl/hazard_ctrl_if.sv | 40 ++++
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: decode sources, EX/MEM writeback tags and the
// resulting forwarding selects, stall and bubble controls.
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    // There is no valid/ready pair here: stall is a level that freezes PC and IF/ID in
    // the cycle it is high, and bubble turns the ID/EX capture into a NOP in that cycle.
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             ex_regwrite;
    logic [REG_W-1:0] ex_rw;
    logic             ex_is_load;
    logic             mem_regwrite;
    logic [REG_W-1:0] mem_rw;
    logic             mem_busy;
    logic             redirect;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall;
    logic             bubble;
    logic [CNT_W-1:0] stall_count;
    logic             dbg_hold;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_regwrite, ex_rw, ex_is_load,
        output mem_regwrite, mem_rw, mem_busy, redirect,
        input  fwd_a, fwd_b, stall, bubble, stall_count, dbg_hold
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_regwrite, ex_rw, ex_is_load,
        input  mem_regwrite, mem_rw, mem_busy, redirect,
        output fwd_a, fwd_b, stall, bubble, stall_count, dbg_hold
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard detection and forwarding for the 5-stage pipeline with a load-use hold FSM.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int LOAD_LAT    = 1,
    parameter int ZERO_REG_EN = 1,
    parameter int CNT_W       = 16
) (
    input logic         clock,
    input logic         reset,
    hazard_ctrl_if.slave hz
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       stall_w;
    logic       bubble_w;
    logic       lu_hazard;

    function automatic logic reg_match(input logic we,
                                       input logic [REG_W-1:0] rw,
                                       input logic [REG_W-1:0] r);
        return we && (rw == r) && !((ZERO_REG_EN != 0) && (r == '0));
    endfunction

    // A load in EX has no result yet, so only MEM can forward in that case.
    function automatic logic [1:0] fwd_sel(input logic use_r,
                                           input logic [REG_W-1:0] r);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_r && reg_match(hz.ex_regwrite, hz.ex_rw, r) && !hz.ex_is_load)
            sel = 2'b01;
        else if (use_r && reg_match(hz.mem_regwrite, hz.mem_rw, r))
            sel = 2'b10;
        return sel;
    endfunction

    always_comb begin
        lu_hazard = hz.ex_is_load &&
                    ((hz.id_use_rs && reg_match(hz.ex_regwrite, hz.ex_rw, hz.id_rs)) ||
                     (hz.id_use_rt && reg_match(hz.ex_regwrite, hz.ex_rw, hz.id_rt)));
    end

    always_comb begin
        hz.fwd_a = 2'b00;
        hz.fwd_b = 2'b00;
        if (!reset) begin
            hz.fwd_a = fwd_sel(hz.id_use_rs, hz.id_rs);
            hz.fwd_b = fwd_sel(hz.id_use_rt, hz.id_rt);
        end
    end

    // Redirect beats busy for the FSM, but a busy memory still has to freeze the PC.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_w  = 1'b0;
        bubble_w = 1'b0;
        if (reset) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (hz.redirect) begin
            stall_w = hz.mem_busy;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (hz.mem_busy) begin
            stall_w = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    stall_w  = lu_hazard;
                    bubble_w = lu_hazard;
                    if (lu_hazard && (LOAD_LAT > 1)) begin
                        state_d = ST_HOLD;
                        cnt_d   = 4'(LOAD_LAT - 1);
                    end
                end
                ST_HOLD: begin
                    stall_w  = 1'b1;
                    bubble_w = 1'b1;
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.stall    = stall_w;
    assign hz.bubble   = bubble_w;
    assign hz.dbg_hold = (state_q == ST_HOLD);

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_w && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign hz.stall_count = stall_cnt_q;
`else
    assign hz.stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl (LOAD_LAT=3) against an owed-stall-cycles model.
module tb_hazard_ctrl;
    localparam int REG_W    = 5;
    localparam int LOAD_LAT = 3;
    localparam int CNT_W    = 16;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   m_left;
    int   exp_count;

    hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.REG_W(REG_W), .LOAD_LAT(LOAD_LAT), .ZERO_REG_EN(1), .CNT_W(CNT_W)) dut (
        .clock(clock),
        .reset(reset),
        .hz   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic hits(input logic we, input logic [REG_W-1:0] rw,
                                  input logic [REG_W-1:0] r);
        return we && (rw == r) && (r != 0);
    endfunction

    function automatic logic [1:0] ref_fwd(input logic use_r, input logic [REG_W-1:0] r);
        if (use_r && hits(bus.ex_regwrite, bus.ex_rw, r) && !bus.ex_is_load) return 2'd1;
        if (use_r && hits(bus.mem_regwrite, bus.mem_rw, r)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic ref_lu();
        return bus.ex_is_load && ((bus.id_use_rs && hits(bus.ex_regwrite, bus.ex_rw, bus.id_rs)) ||
                                  (bus.id_use_rt && hits(bus.ex_regwrite, bus.ex_rw, bus.id_rt)));
    endfunction

    // m_left = stall cycles still owed by the load currently being waited out.
    function automatic logic [5:0] ref_out();
        logic st, bu;
        st = 1'b0;
        bu = 1'b0;
        if (reset) return 6'b0;
        if (bus.redirect) st = bus.mem_busy;
        else if (bus.mem_busy) st = 1'b1;
        else if (m_left > 0) begin st = 1'b1; bu = 1'b1; end
        else begin st = ref_lu(); bu = st; end
        return {st, bu, ref_fwd(bus.id_use_rs, bus.id_rs), ref_fwd(bus.id_use_rt, bus.id_rt)};
    endfunction

    function automatic logic [CNT_W-1:0] exp_sc();
`ifdef HAZARD_STATS_EN
        return CNT_W'(exp_count);
`else
        return '0;
`endif
    endfunction

    task automatic tick();
        logic [5:0] o;
        o = ref_out();
        if (reset) begin
            m_left    = 0;
            exp_count = 0;
        end else begin
            if (o[5] && exp_count < CNT_MAX) exp_count++;
            if (bus.redirect) m_left = 0;
            else if (!bus.mem_busy) begin
                if (m_left > 0) m_left--;
                else if (ref_lu()) m_left = LOAD_LAT - 1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
        bus.ex_regwrite = 1'b0; bus.ex_rw = '0; bus.ex_is_load = 1'b0;
        bus.mem_regwrite = 1'b0; bus.mem_rw = '0; bus.mem_busy = 1'b0; bus.redirect = 1'b0;
    endtask

    task automatic load_in_ex(input logic [REG_W-1:0] r);
        idle_inputs();
        bus.ex_regwrite = 1'b1; bus.ex_rw = r; bus.ex_is_load = 1'b1;
        bus.id_rs = r; bus.id_use_rs = 1'b1;
    endtask

    task automatic load_in_mem(input logic [REG_W-1:0] r);
        bus.ex_regwrite = 1'b0; bus.ex_is_load = 1'b0;
        bus.mem_regwrite = 1'b1; bus.mem_rw = r;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        reset = 1'b1;
        load_in_ex(5'd5);
        bus.mem_busy = 1'b1;
        @(negedge clock);
        obs = {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b};
        checks++;
        if (obs !== 6'b0) begin failures++; $display("FAIL reset_outputs: got %b expected %b", obs, 6'b0); end
        tick();
        reset = 1'b0;
        idle_inputs();
        @(negedge clock);
        checks++;
        if (bus.stall_count !== exp_sc()) begin
            failures++; $display("FAIL reset_count: got %0d expected %0d", bus.stall_count, exp_sc());
        end
        obs = {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b};
        checks++;
        if (obs !== 6'b0) begin failures++; $display("FAIL post_reset_idle: got %b expected %b", obs, 6'b0); end
        tick();
    endtask

    task automatic test_forward_ex();
        logic [5:0] obs;
        idle_inputs();
        bus.ex_regwrite = 1'b1; bus.ex_rw = 5'd5; bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
        @(negedge clock);
        obs = {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b};
        checks++;
        if (obs !== 6'b00_01_00) begin failures++; $display("FAIL forward_ex: got %b expected %b", obs, 6'b00_01_00); end
        tick();
    endtask

    task automatic test_ex_priority();
        logic [5:0] obs;
        idle_inputs();
        bus.ex_regwrite = 1'b1; bus.ex_rw = 5'd5; bus.mem_regwrite = 1'b1; bus.mem_rw = 5'd5;
        bus.id_rt = 5'd5; bus.id_use_rt = 1'b1; bus.id_rs = 5'd3; bus.id_use_rs = 1'b1;
        @(negedge clock);
        obs = {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b};
        checks++;
        if (obs !== 6'b00_00_01) begin failures++; $display("FAIL ex_priority: got %b expected %b", obs, 6'b00_00_01); end
        tick();
        bus.ex_regwrite = 1'b0;
        @(negedge clock);
        obs = {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b};
        checks++;
        if (obs !== 6'b00_00_10) begin failures++; $display("FAIL mem_forward: got %b expected %b", obs, 6'b00_00_10); end
        tick();
    endtask

    task automatic test_load_use();
        logic [5:0] obs;
        load_in_ex(5'd8);
        @(negedge clock);
        obs = {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b};
        checks++;
        if (obs !== 6'b11_00_00) begin failures++; $display("FAIL load_use_c0: got %b expected %b", obs, 6'b11_00_00); end
        tick();
        load_in_mem(5'd8);
        for (int i = 1; i < 3; i++) begin
            @(negedge clock);
            obs = {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b};
            checks++;
            if (obs !== 6'b11_10_00) begin failures++; $display("FAIL load_use_c%0d: got %b expected %b", i, obs, 6'b11_10_00); end
            tick();
        end
        @(negedge clock);
        obs = {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b};
        checks++;
        if (obs !== 6'b00_10_00) begin failures++; $display("FAIL load_use_release: got %b expected %b", obs, 6'b00_10_00); end
        checks++;
        if (bus.stall_count !== exp_sc()) begin
            failures++; $display("FAIL load_use_count: got %0d expected %0d", bus.stall_count, exp_sc());
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_busy_hold();
        logic [1:0] sb;
        logic [1:0] exp_sb [6];
        int         nstall;
        exp_sb = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00};
        nstall = 0;
        load_in_ex(5'd9);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) load_in_mem(5'd9);
            bus.mem_busy = (i == 2 || i == 3);
            @(negedge clock);
            sb = {bus.stall, bus.bubble};
            if (sb[1]) nstall++;
            checks++;
            if (sb !== exp_sb[i]) begin failures++; $display("FAIL busy_hold_c%0d: got %b expected %b", i, sb, exp_sb[i]); end
            tick();
        end
        checks++;
        if (nstall !== 5) begin failures++; $display("FAIL busy_hold_total: got %0d expected 5", nstall); end
        idle_inputs();
    endtask

    task automatic test_zero_reg();
        logic [5:0] obs;
        idle_inputs();
        bus.ex_regwrite = 1'b1; bus.ex_rw = '0; bus.ex_is_load = 1'b1;
        bus.mem_regwrite = 1'b1; bus.mem_rw = '0;
        bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1;
        @(negedge clock);
        obs = {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b};
        checks++;
        if (obs !== 6'b0) begin failures++; $display("FAIL zero_reg_load: got %b expected %b", obs, 6'b0); end
        tick();
        bus.ex_is_load = 1'b0;
        @(negedge clock);
        obs = {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b};
        checks++;
        if (obs !== 6'b0) begin failures++; $display("FAIL zero_reg_alu: got %b expected %b", obs, 6'b0); end
        tick();
    endtask

    task automatic test_redirect();
        logic [5:0] obs;
        for (int v = 0; v < 2; v++) begin
            load_in_ex(5'd7);
            @(negedge clock);
            tick();
            load_in_mem(5'd7);
            @(negedge clock);
            checks++;
            if (bus.stall !== 1'b1) begin failures++; $display("FAIL redirect_hold%0d: stall got %b expected 1", v, bus.stall); end
            tick();
            bus.redirect = 1'b1;
            bus.mem_busy = (v == 1);
            @(negedge clock);
            obs = {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b};
            checks++;
            if (obs !== {(v == 1), 5'b0_10_00}) begin
                failures++; $display("FAIL redirect_cycle%0d: got %b expected %b", v, obs, {(v == 1), 5'b0_10_00});
            end
            tick();
            bus.redirect = 1'b0;
            bus.mem_busy = 1'b0;
            @(negedge clock);
            obs = {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b};
            checks++;
            if (obs !== 6'b00_10_00) begin failures++; $display("FAIL redirect_after%0d: got %b expected %b", v, obs, 6'b00_10_00); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_hold();
        logic [5:0] obs;
        load_in_ex(5'd6);
        @(negedge clock);
        tick();
        load_in_mem(5'd6);
        reset = 1'b1;
        @(negedge clock);
        obs = {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b};
        checks++;
        if (obs !== 6'b0) begin failures++; $display("FAIL reset_mid_hold: got %b expected %b", obs, 6'b0); end
        tick();
        reset = 1'b0;
        @(negedge clock);
        obs = {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b};
        checks++;
        if (obs !== 6'b00_10_00) begin failures++; $display("FAIL reset_mid_after: got %b expected %b", obs, 6'b00_10_00); end
        checks++;
        if (bus.stall_count !== 16'd0) begin failures++; $display("FAIL reset_mid_count: got %0d expected 0", bus.stall_count); end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        logic [5:0] obs, exp;
        for (int i = 0; i < 400; i++) begin
            bus.id_rs        = REG_W'($urandom_range(0, 3));
            bus.id_rt        = REG_W'($urandom_range(0, 3));
            bus.id_use_rs    = 1'($urandom_range(0, 1));
            bus.id_use_rt    = 1'($urandom_range(0, 1));
            bus.ex_regwrite  = 1'($urandom_range(0, 1));
            bus.ex_rw        = REG_W'($urandom_range(0, 3));
            bus.ex_is_load   = ($urandom_range(0, 2) == 0);
            bus.mem_regwrite = 1'($urandom_range(0, 1));
            bus.mem_rw       = REG_W'($urandom_range(0, 3));
            bus.mem_busy     = ($urandom_range(0, 4) == 0);
            bus.redirect     = ($urandom_range(0, 9) == 0);
            reset            = ($urandom_range(0, 39) == 0);
            @(negedge clock);
            obs = {bus.stall, bus.bubble, bus.fwd_a, bus.fwd_b};
            exp = ref_out();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL random_outputs[%0d]: got %b expected %b", i, obs, exp); end
            checks++;
            if (bus.stall_count !== exp_sc()) begin
                failures++; $display("FAIL random_count[%0d]: got %0d expected %0d", i, bus.stall_count, exp_sc());
            end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        m_left    = 0;
        exp_count = 0;
        reset     = 1'b1;
        idle_inputs();
        @(posedge clock);
        #1;
        test_reset();
        test_forward_ex();
        test_ex_priority();
        test_load_use();
        test_busy_hold();
        test_zero_reg();
        test_redirect();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
